hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It sequences the decode stage and its neighbours by driving pipeline-register write enables and flushes. It resolves load-use hazards with a one-cycle bubble, squashes wrong-path instructions on taken branches and jumps, and freezes the pipe while data memory is busy. It also produces EX operand forwarding selects, keeps saturating stall/flush performance counters, and latches a sticky error if a memory wait exceeds a timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive dmem_busy cycles before the block halts.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination of the instruction in EX.
- ex_reg_write, ex_mem_read  in  1 each  EX instruction writes a register / is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- mem_rd, mem_reg_write  in  5, 1  destination and write flag of the instruction in MEM.
- wb_rd, wb_reg_write  in  5, 1  destination and write flag of the instruction in WB.
- dmem_busy  in  1  data memory not ready this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP) into that register.
- forward_a, forward_b  out  2 each  EX operand select: 00 register file, 10 from EX/MEM, 01 from MEM/WB.
- stall_count, flush_count  out  CNT_W each  saturating performance counters.
- timeout_err  out  1  sticky; set when the block enters HALT.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- Control outputs are Mealy: they depend on the current state and the current inputs. Priority, highest first: HALT, then dmem_busy, then ex_redirect, then load-use.
- HALT: all four enables are 0 and both flushes are 0. HALT is left only by reset.
- dmem_busy=1 in RUN or MEM_WAIT is a freeze:
  - all enables are 0 and both flushes are 0;
  - the next state is MEM_WAIT;
  - wait_cnt increments.
- In MEM_WAIT, if dmem_busy=0, behave exactly as RUN this cycle and return to RUN. wait_cnt clears on any non-busy cycle.
- Timeout: if dmem_busy=1 and wait_cnt==MEM_TIMEOUT-1, the next state is HALT and timeout_err is set.
- Redirect (ex_redirect=1, not frozen):
  - pc_write=1, if_id_flush=1, id_ex_flush=1;
  - the other enables are 1;
  - flush_count increments.
- Load-use (not frozen, no redirect). Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)). Response:
  - pc_write=0, if_id_write=0;
  - id_ex_flush=1;
  - id_ex_write=1, ex_mem_write=1.
- Normal cycle: all enables are 1 and both flushes are 0.
- stall_count increments on every freeze or load-use cycle.
- Both counters saturate at all-ones and never wrap.
- Forwarding (combinational, independent of state), per operand:
  - 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rsN;
  - else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rsN;
  - else 00.
  - The EX/MEM source beats MEM/WB.

## Timing
- Control and forward outputs are zero-latency combinational. Counters, wait_cnt, state and timeout_err update on the rising clk edge.
- While rst=0 (asynchronous, effective immediately):
  - state=RUN, counters=0, wait_cnt=0, timeout_err=0;
  - all enables 0, both flushes 1, forward_a/b=00.
- After rst deasserts, the first edge evaluates RUN.
- Reset during MEM_WAIT or HALT returns to RUN and clears timeout_err.
- A load-use bubble lasts exactly one cycle. On the next cycle the load is in MEM, and forwarding from MEM/WB covers the operand one cycle later.
- Redirect and load-use in the same cycle: redirect wins, and stall_count does not increment.

## Structure
- The shared package rv32i_pkg holds:
  - forward encodings FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
  - the hz_state_t enum {RUN, MEM_WAIT, HALT}.
- One sub-module, forward_unit, contains the combinational forward_a/forward_b logic. The FSM, stall logic and counters stay in hazard_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_count goes 0→1.
- Load to x0: same as above but ex_rd=0 → no stall. Also mem_rd=0 with ex_rs1=0 → forward_a=00.
- Forward priority: ex_rs1=7, mem_rd=7, wb_rd=7, both write flags 1 → forward_a=10. Drop mem_reg_write → forward_a=01.
- Redirect plus load-use in the same cycle → if_id_flush=id_ex_flush=pc_write=1; flush_count+1; stall_count unchanged.
- dmem_busy high for 3 cycles with MEM_TIMEOUT=4 → 3 frozen cycles, then RUN, timeout_err=0, stall_count+3. Busy for 4 cycles → HALT, timeout_err=1; dropping dmem_busy leaves everything frozen.
- Assert rst low mid-HALT, then release → state RUN, timeout_err=0, counters 0, normal enables restored on the first cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions.
// Forwarding encodings, hazard FSM states and the forward select helper.
package rv32i_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      HALT
   } hz_state_t;

   // EX/MEM result is younger than MEM/WB, so it wins.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] mem_rd,
      input logic       mem_we,
      input logic [4:0] wb_rd,
      input logic       wb_we
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
         sel = FWD_MEM;
      else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// EX operand forwarding select.
// Purely combinational; independent of the hazard FSM.
module forward_unit
   import rv32i_pkg::*;
(
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b
);

   // Pick the youngest in-flight producer for each EX source.
   always_comb begin
      forward_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write,
                          wb_rd, wb_reg_write);
      forward_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write,
                          wb_rd, wb_reg_write);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, memory freeze,
// forwarding selects, perf counters and memory-wait timeout.
module hazard_ctrl
   import rv32i_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             timeout_err
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   hz_state_t      state;
   hz_state_t      state_n;
   logic [WCW-1:0] wait_cnt;
   logic           wait_inc;
   logic           wait_clr;
   logic           stall_inc;
   logic           flush_inc;
   logic           timeout_set;
   logic           load_use;
   logic [1:0]     fwd_a_raw;
   logic [1:0]     fwd_b_raw;
   logic           unused_ok;

   // Load writes a register by definition; only the load flag matters.
   assign unused_ok = ex_reg_write;

   // A load in EX feeding the instruction in ID needs one bubble.
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   forward_unit u_fwd (
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .mem_rd       (mem_rd),
      .mem_reg_write(mem_reg_write),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .forward_a    (fwd_a_raw),
      .forward_b    (fwd_b_raw)
   );

   assign forward_a = rst ? fwd_a_raw : FWD_RF;
   assign forward_b = rst ? fwd_b_raw : FWD_RF;

   // Next state and Mealy controls, highest priority first.
   always_comb begin
      state_n      = state;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      wait_inc     = 1'b0;
      wait_clr     = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      timeout_set  = 1'b0;
      if (!rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         state_n      = RUN;
      end else if (state == HALT) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (dmem_busy) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         wait_inc     = 1'b1;
         stall_inc    = 1'b1;
         if (wait_cnt == WAIT_LAST) begin
            state_n     = HALT;
            timeout_set = 1'b1;
         end else begin
            state_n = MEM_WAIT;
         end
      end else begin
         wait_clr = 1'b1;
         state_n  = RUN;
         if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
         end
      end
   end

   // State, wait counter, saturating perf counters, sticky timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         stall_count <= '0;
         flush_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_n;
         if (wait_clr)
            wait_cnt <= '0;
         else if (wait_inc)
            wait_cnt <= wait_cnt + 1'b1;
         if (stall_inc && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if (flush_inc && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
         if (timeout_set)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the
// single-cycle function, hand sequences for freeze/timeout/reset.
module tb_hazard_ctrl;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam logic [5:0] NRM = 6'b111100;
   localparam logic [5:0] LU  = 6'b001101;
   localparam logic [5:0] RD  = 6'b111111;
   localparam logic [5:0] FRZ = 6'b000000;
   localparam logic [5:0] RST = 6'b000011;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
   logic [4:0]    mem_rd, wb_rd;
   logic          id_use_rs1, id_use_rs2;
   logic          ex_reg_write, ex_mem_read, ex_redirect;
   logic          mem_reg_write, wb_reg_write, dmem_busy;
   logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic          if_id_flush, id_ex_flush;
   logic [1:0]    forward_a, forward_b;
   logic [CW-1:0] stall_count, flush_count;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   typedef struct {
      logic [4:0] i_rs1;
      logic [4:0] i_rs2;
      logic       u1;
      logic       u2;
      logic [4:0] e_rs1;
      logic [4:0] e_rs2;
      logic [4:0] e_rd;
      logic       e_mr;
      logic       e_rw;
      logic       redir;
      logic [4:0] m_rd;
      logic       m_rw;
      logic [4:0] w_rd;
      logic       w_rw;
      logic [5:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
      int         st;
      int         fl;
   } vec_t;

   vec_t vecs[14];

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst_n),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_redirect  (ex_redirect),
      .mem_rd       (mem_rd),
      .mem_reg_write(mem_reg_write),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .dmem_busy    (dmem_busy),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_write  (id_ex_write),
      .ex_mem_write (ex_mem_write),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .forward_a    (forward_a),
      .forward_b    (forward_b),
      .stall_count  (stall_count),
      .flush_count  (flush_count),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ctl_now();
      return {pc_write, if_id_write, id_ex_write, ex_mem_write,
              if_id_flush, id_ex_flush};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_redirect = 0;
      mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
      dmem_busy = 0;
   endtask

   task automatic drive(input vec_t v);
      id_rs1 = v.i_rs1; id_rs2 = v.i_rs2;
      id_use_rs1 = v.u1; id_use_rs2 = v.u2;
      ex_rs1 = v.e_rs1; ex_rs2 = v.e_rs2; ex_rd = v.e_rd;
      ex_mem_read = v.e_mr; ex_reg_write = v.e_rw;
      ex_redirect = v.redir;
      mem_rd = v.m_rd; mem_reg_write = v.m_rw;
      wb_rd = v.w_rd; wb_reg_write = v.w_rw;
      dmem_busy = 0;
   endtask

   task automatic set_load_use();
      idle();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
      id_rs1 = 5; id_use_rs1 = 1;
   endtask

   initial begin
      vecs[0]  = '{0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, NRM,2'b00,2'b00,0,0};
      vecs[1]  = '{5,0,1,0, 0,0, 5,1,1,0, 0,0,0,0, LU, 2'b00,2'b00,1,0};
      vecs[2]  = '{5,9,1,1, 0,0, 9,1,1,0, 0,0,0,0, LU, 2'b00,2'b00,1,0};
      vecs[3]  = '{5,0,0,0, 0,0, 5,1,1,0, 0,0,0,0, NRM,2'b00,2'b00,0,0};
      vecs[4]  = '{0,0,1,0, 0,0, 0,1,1,0, 0,1,0,0, NRM,2'b00,2'b00,0,0};
      vecs[5]  = '{5,0,1,0, 0,0, 5,0,1,0, 0,0,0,0, NRM,2'b00,2'b00,0,0};
      vecs[6]  = '{0,0,0,0, 7,0, 0,0,0,0, 7,1,7,1, NRM,2'b10,2'b00,0,0};
      vecs[7]  = '{0,0,0,0, 7,0, 0,0,0,0, 7,0,7,1, NRM,2'b01,2'b00,0,0};
      vecs[8]  = '{0,0,0,0, 4,3, 0,0,0,0, 3,0,3,1, NRM,2'b00,2'b01,0,0};
      vecs[9]  = '{0,0,0,0,12,12,0,0,0,0,12,1,0,0, NRM,2'b10,2'b10,0,0};
      vecs[10] = '{5,0,1,0, 0,0, 5,1,1,1, 0,0,0,0, RD, 2'b00,2'b00,0,1};
      vecs[11] = '{0,0,0,0, 0,0, 0,0,0,1, 0,0,0,0, RD, 2'b00,2'b00,0,1};
      vecs[12] = '{0,0,0,0, 0,0, 0,0,0,0, 0,0,0,1, NRM,2'b00,2'b00,0,0};
      vecs[13] = '{0,0,0,0, 2,8, 0,0,0,0, 8,1,2,1, NRM,2'b01,2'b10,0,0};

      idle();
      #1;
      chk("reset_ctl", int'(ctl_now()), int'(RST));
      chk("reset_stall", int'(stall_count), 0);
      chk("reset_terr", int'(timeout_err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("vec%0d_ctl", i), int'(ctl_now()), int'(vecs[i].ctl));
         chk($sformatf("vec%0d_fa", i), int'(forward_a), int'(vecs[i].fa));
         chk($sformatf("vec%0d_fb", i), int'(forward_b), int'(vecs[i].fb));
         exp_stall += vecs[i].st;
         exp_flush += vecs[i].fl;
      end
      @(negedge clk);
      chk("tbl_stall", int'(stall_count), exp_stall);
      chk("tbl_flush", int'(flush_count), exp_flush);
      idle();

      for (int i = 0; i < 3; i++) begin
         dmem_busy = 1;
         #1;
         chk($sformatf("busy3_c%0d", i), int'(ctl_now()), int'(FRZ));
         exp_stall++;
         @(negedge clk);
      end
      set_load_use();
      #1;
      chk("wait_exit_lu", int'(ctl_now()), int'(LU));
      exp_stall++;
      @(negedge clk);
      chk("busy3_stall", int'(stall_count), exp_stall);
      chk("busy3_terr", int'(timeout_err), 0);
      idle();
      #1;
      chk("busy3_run", int'(ctl_now()), int'(NRM));
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         dmem_busy = 1;
         #1;
         chk($sformatf("busy4_c%0d", i), int'(ctl_now()), int'(FRZ));
         exp_stall++;
         @(negedge clk);
      end
      chk("halt_terr", int'(timeout_err), 1);
      idle();
      #1;
      chk("halt_ctl", int'(ctl_now()), int'(FRZ));
      set_load_use();
      ex_redirect = 1;
      #1;
      chk("halt_redir_ctl", int'(ctl_now()), int'(FRZ));
      @(negedge clk);
      chk("halt_stall", int'(stall_count), exp_stall);
      chk("halt_flush", int'(flush_count), exp_flush);

      idle();
      ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1;
      rst_n = 1'b0;
      #1;
      chk("rst_halt_ctl", int'(ctl_now()), int'(RST));
      chk("rst_halt_fa", int'(forward_a), 0);
      chk("rst_halt_terr", int'(timeout_err), 0);
      chk("rst_halt_stall", int'(stall_count), 0);
      chk("rst_halt_flush", int'(flush_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      #1;
      chk("post_rst_ctl", int'(ctl_now()), int'(NRM));
      @(negedge clk);
      chk("post_rst_stall", int'(stall_count), 0);

      set_load_use();
      ex_redirect = 1;
      #1;
      chk("redir_lu_ctl", int'(ctl_now()), int'(RD));
      @(negedge clk);
      chk("redir_lu_stall", int'(stall_count), 0);
      chk("redir_lu_flush", int'(flush_count), 1);

      set_load_use();
      repeat (20) @(negedge clk);
      chk("sat_stall", int'(stall_count), 15);
      idle();
      ex_redirect = 1;
      repeat (20) @(negedge clk);
      chk("sat_flush", int'(flush_count), 15);
      idle();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
